// File: rtl/dflow_replay_engine.sv
// Record store/replay engine over a QDR word region; rd_valid->out_vld 1 cycle, reads credit-limited by FIFO_DEPTH.
// Output is FWFT valid/ready with stalls holding data; optional counters under `DFLOW_REPLAY_STATS_EN.
module dflow_replay_engine #(
    parameter int TUPLE_W    = 104,
    parameter int LEN_W      = 16,
    parameter int MEM_ADDR_W = 19,
    parameter int MEM_DATA_W = 144,
    parameter int FIFO_DEPTH = 16,
    parameter int LOOP_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_rst,
    input  logic                  start_store,
    input  logic                  start_replay,
    input  logic                  stop,
    input  logic [MEM_ADDR_W-1:0] mem_addr_low,
    input  logic [MEM_ADDR_W-1:0] mem_addr_high,
    input  logic [LOOP_W-1:0]     loop_count,
    output logic                  busy,
    output logic                  replay_done,
    output logic                  region_full,
    output logic                  cfg_err,
    output logic [MEM_ADDR_W:0]   stored_count,
    input  logic                  init_calib_complete,
    output logic                  mem_wr_cmd,
    output logic [MEM_ADDR_W-1:0] mem_wr_addr,
    output logic [MEM_DATA_W-1:0] mem_wr_data,
    output logic                  mem_rd_cmd,
    output logic [MEM_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_rd_valid,
    input  logic [MEM_DATA_W-1:0] mem_rd_data,
    input  logic [TUPLE_W-1:0]    tuple_in,
    input  logic [LEN_W-1:0]      len_in,
    input  logic                  in_vld,
    output logic                  in_ready,
    output logic [TUPLE_W-1:0]    tuple_out,
    output logic [LEN_W-1:0]      len_out,
    output logic                  out_vld,
    input  logic                  out_ready,
    output logic [31:0]           stat_records,
    output logic [31:0]           stat_stalls
);
    localparam int REC_W = TUPLE_W + LEN_W;
    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int FC_W  = FA_W + 1;
    localparam logic [FC_W:0] DEPTH_C = (FC_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_REPLAY, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [MEM_ADDR_W-1:0] low_q, low_d, high_q, high_d, last_q, last_d;
    logic [MEM_ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOOP_W-1:0]     loop_q, loop_d, pass_q, pass_d;
    logic [MEM_ADDR_W:0]   stored_q, stored_d;
    logic                  region_full_q, region_full_d, cfg_err_q, cfg_err_d;
    logic                  replay_done_q, replay_done_d;
    logic [FC_W-1:0]       outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
    logic [FA_W-1:0]       fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [REC_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [REC_W-1:0]      rec_head;
    logic                  rst, wr_fire, rd_fire, rd_push, pop, credit_ok, replay_start;

    assign rst       = reset | sw_rst;
    assign wr_fire   = in_vld && (state_q == S_STORE);
    assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
    assign rd_fire   = (state_q == S_REPLAY) && !stop && credit_ok;
    // Returns with nothing outstanding belong to a replay killed by reset.
    assign rd_push   = mem_rd_valid && (outst_q != '0);
    assign pop       = out_vld && out_ready;

    always_comb begin
        state_d       = state_q;
        low_d         = low_q;
        high_d        = high_q;
        last_d        = last_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        loop_d        = loop_q;
        pass_d        = pass_q;
        stored_d      = stored_q;
        region_full_d = region_full_q;
        cfg_err_d     = cfg_err_q;
        replay_done_d = 1'b0;
        replay_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (init_calib_complete && start_store) begin
                    if (mem_addr_high < mem_addr_low) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d       = S_STORE;
                        high_d        = mem_addr_high;
                        wr_ptr_d      = mem_addr_low;
                        stored_d      = '0;
                        region_full_d = 1'b0;
                    end
                end else if (init_calib_complete && start_replay) begin
                    if ((mem_addr_high < mem_addr_low) || (stored_q == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d      = S_REPLAY;
                        low_d        = mem_addr_low;
                        rd_ptr_d     = mem_addr_low;
                        last_d       = mem_addr_low + stored_q[MEM_ADDR_W-1:0] - MEM_ADDR_W'(1);
                        loop_d       = loop_count;
                        pass_d       = '0;
                        replay_start = 1'b1;
                    end
                end
            end
            S_STORE: begin
                if (wr_fire) begin
                    wr_ptr_d = wr_ptr_q + MEM_ADDR_W'(1);
                    stored_d = stored_q + (MEM_ADDR_W+1)'(1);
                    if (wr_ptr_q == high_q) begin
                        region_full_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
                if (stop) state_d = S_IDLE;
            end
            S_REPLAY: begin
                if (stop) begin
                    state_d = S_DRAIN;
                end else if (rd_fire) begin
                    if (rd_ptr_q == last_q) begin
                        rd_ptr_d = low_q;
                        pass_d   = pass_q + LOOP_W'(1);
                        if ((loop_q != '0) && ((pass_q + LOOP_W'(1)) == loop_q)) state_d = S_DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + MEM_ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((outst_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d       = S_IDLE;
                    replay_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        outst_d = outst_q;
        if (rd_fire && !rd_push)      outst_d = outst_q + FC_W'(1);
        else if (!rd_fire && rd_push) outst_d = outst_q - FC_W'(1);
        fifo_cnt_d = fifo_cnt_q;
        if (rd_push && !pop)          fifo_cnt_d = fifo_cnt_q + FC_W'(1);
        else if (!rd_push && pop)     fifo_cnt_d = fifo_cnt_q - FC_W'(1);
        fifo_wp_d = fifo_wp_q + FA_W'(rd_push);
        fifo_rp_d = fifo_rp_q + FA_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            low_q         <= '0;
            high_q        <= '0;
            last_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            loop_q        <= '0;
            pass_q        <= '0;
            stored_q      <= '0;
            region_full_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            replay_done_q <= 1'b0;
            outst_q       <= '0;
            fifo_cnt_q    <= '0;
            fifo_wp_q     <= '0;
            fifo_rp_q     <= '0;
        end else begin
            state_q       <= state_d;
            low_q         <= low_d;
            high_q        <= high_d;
            last_q        <= last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            loop_q        <= loop_d;
            pass_q        <= pass_d;
            stored_q      <= stored_d;
            region_full_q <= region_full_d;
            cfg_err_q     <= cfg_err_d;
            replay_done_q <= replay_done_d;
            outst_q       <= outst_d;
            fifo_cnt_q    <= fifo_cnt_d;
            fifo_wp_q     <= fifo_wp_d;
            fifo_rp_q     <= fifo_rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) fifo_mem[fifo_wp_q] <= mem_rd_data[REC_W-1:0];
    end

    generate
        if (MEM_DATA_W > REC_W) begin : g_rd_pad
            logic unused_rd_pad;
            assign unused_rd_pad = ^mem_rd_data[MEM_DATA_W-1:REC_W];
        end
    endgenerate

    assign rec_head     = fifo_mem[fifo_rp_q];
    assign busy         = (state_q != S_IDLE);
    assign replay_done  = replay_done_q;
    assign region_full  = region_full_q;
    assign cfg_err      = cfg_err_q;
    assign stored_count = stored_q;
    assign in_ready     = (state_q == S_STORE);
    assign mem_wr_cmd   = wr_fire;
    assign mem_wr_addr  = wr_ptr_q;
    assign mem_wr_data  = MEM_DATA_W'({tuple_in, len_in});
    assign mem_rd_cmd   = rd_fire;
    assign mem_rd_addr  = rd_ptr_q;
    assign out_vld      = (fifo_cnt_q != '0);
    assign tuple_out    = out_vld ? rec_head[REC_W-1:LEN_W] : '0;
    assign len_out      = out_vld ? rec_head[LEN_W-1:0] : '0;

`ifdef DFLOW_REPLAY_STATS_EN
    logic [31:0] stat_rec_q, stat_stall_q;
    always_ff @(posedge clk) begin
        if (rst || replay_start) begin
            stat_rec_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pop && (stat_rec_q != '1)) stat_rec_q <= stat_rec_q + 32'd1;
            if (out_vld && !out_ready && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end
    assign stat_records = stat_rec_q;
    assign stat_stalls  = stat_stall_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = replay_start;
    assign stat_records     = '0;
    assign stat_stalls      = '0;
`endif
endmodule

// File: tb/tb_dflow_replay_engine.sv
// Directed bench for dflow_replay_engine with a 2-cycle QDR read model.
module tb_dflow_replay_engine;
    localparam int TW = 104, LW = 16, AW = 19, DW = 144, FD = 16, LPW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, sw_rst = 1'b0, start_store = 1'b0, start_replay = 1'b0, stop = 1'b0;
    logic [AW-1:0] mem_addr_low = '0, mem_addr_high = '0;
    logic [LPW-1:0] loop_count = '0;
    logic          busy, replay_done, region_full, cfg_err;
    logic [AW:0]   stored_count;
    logic          init_calib_complete = 1'b1;
    logic          mem_wr_cmd, mem_rd_cmd;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic [TW-1:0] tuple_in = '0, tuple_out;
    logic [LW-1:0] len_in = '0, len_out;
    logic          in_vld = 1'b0, in_ready, out_vld, out_ready = 1'b0;
    logic [31:0]   stat_records, stat_stalls;

    dflow_replay_engine #(.TUPLE_W(TW), .LEN_W(LW), .MEM_ADDR_W(AW), .MEM_DATA_W(DW),
                          .FIFO_DEPTH(FD), .LOOP_W(LPW)) dut (
        .clk(clk), .reset(reset), .sw_rst(sw_rst), .start_store(start_store),
        .start_replay(start_replay), .stop(stop), .mem_addr_low(mem_addr_low),
        .mem_addr_high(mem_addr_high), .loop_count(loop_count), .busy(busy),
        .replay_done(replay_done), .region_full(region_full), .cfg_err(cfg_err),
        .stored_count(stored_count), .init_calib_complete(init_calib_complete),
        .mem_wr_cmd(mem_wr_cmd), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_cmd(mem_rd_cmd), .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .tuple_in(tuple_in), .len_in(len_in), .in_vld(in_vld),
        .in_ready(in_ready), .tuple_out(tuple_out), .len_out(len_out), .out_vld(out_vld),
        .out_ready(out_ready), .stat_records(stat_records), .stat_stalls(stat_stalls));

    int n_checks = 0, n_fail = 0;

    // Memory model and monitors, all sampled on the falling edge.
    logic [DW-1:0] mem_model [256];
    logic          pv0 = 1'b0, pv1 = 1'b0;
    logic [7:0]    pa0 = '0, pa1 = '0;
    int            rd_cnt = 0, pop_cnt = 0, done_cnt = 0, busy_cnt = 0, max_occ = 0;
    logic [AW-1:0] wr_aq [$];
    logic [DW-1:0] wr_dq [$];
    logic [TW-1:0] out_tq [$];
    logic [LW-1:0] out_lq [$];

    always @(negedge clk) begin
        if (mem_wr_cmd) begin
            wr_aq.push_back(mem_wr_addr);
            wr_dq.push_back(mem_wr_data);
            mem_model[mem_wr_addr[7:0]] = mem_wr_data;
        end
        mem_rd_valid = pv1;
        mem_rd_data  = mem_model[pa1];
        pv1 = pv0;
        pa1 = pa0;
        pv0 = mem_rd_cmd;
        pa0 = mem_rd_addr[7:0];
        if (mem_rd_cmd) rd_cnt++;
        if (rd_cnt - pop_cnt > max_occ) max_occ = rd_cnt - pop_cnt;
        if (out_vld && out_ready) begin
            out_tq.push_back(tuple_out);
            out_lq.push_back(len_out);
            pop_cnt++;
        end
        if (replay_done) done_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TW-1:0] rec_t(input int i);
        rec_t = {40'hABCDE12345, 32'(i) * 32'h01010101, 32'hF00D0000 + 32'(i)};
    endfunction

    function automatic logic [LW-1:0] rec_l(input int i);
        rec_l = 16'(64 + 3 * i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_store_at(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        mem_addr_low  = lo;
        mem_addr_high = hi;
        start_store   = 1'b1;
        tick();
        start_store = 1'b0;
    endtask

    task automatic start_replay_at(input logic [AW-1:0] lo, input logic [LPW-1:0] loops);
        mem_addr_low  = lo;
        mem_addr_high = lo + 19'h0F;
        loop_count    = loops;
        start_replay  = 1'b1;
        tick();
        start_replay = 1'b0;
    endtask

    task automatic store_recs(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_vld   = 1'b1;
            tuple_in = rec_t(base + i);
            len_in   = rec_l(base + i);
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int db, input int budget, input string name);
        for (int c = 0; c < budget && done_cnt == db; c++) tick();
        n_checks++;
        if (done_cnt == db) begin
            n_fail++;
            $display("FAIL %s_timeout: replay_done pulses got %0d want >=1", name, done_cnt - db);
        end
        repeat (5) tick();
    endtask

    task automatic check_outputs(input int ob, input int n, input int base, input string name);
        n_checks++;
        if (out_tq.size() - ob != n) begin
            n_fail++;
            $display("FAIL %s_count: outputs got %0d want %0d", name, out_tq.size() - ob, n);
        end
        for (int i = 0; i < n && ob + i < out_tq.size(); i++) begin
            n_checks++;
            if (out_tq[ob+i] !== rec_t(base + i % 3) || out_lq[ob+i] !== rec_l(base + i % 3)) begin
                n_fail++;
                $display("FAIL %s_rec%0d: got %h/%h want %h/%h", name, i, out_tq[ob+i], out_lq[ob+i],
                         rec_t(base + i % 3), rec_l(base + i % 3));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, out_vld, mem_wr_cmd, mem_rd_cmd, region_full, cfg_err, replay_done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {busy, in_ready, out_vld, mem_wr_cmd, mem_rd_cmd, region_full, cfg_err, replay_done});
        end
        n_checks++;
        if (stored_count !== 20'd0 || stat_records !== 32'd0 || stat_stalls !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: stored %0d rec %0d stall %0d want 0", stored_count, stat_records, stat_stalls);
        end
    endtask

    task automatic test_store_full();
        int wb;
        tick();
        wb = wr_aq.size();
        start_store_at(19'h10, 19'h13);
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL s1_entry: busy/in_ready got %b want 11", {busy, in_ready});
        end
        tick();
        store_recs(0, 4);
        @(negedge clk);
        n_checks++;
        if ({region_full, in_ready, busy} !== 3'b100 || stored_count !== 20'd4) begin
            n_fail++;
            $display("FAIL s1_full: full/in_ready/busy %b stored %0d want 100 stored 4",
                     {region_full, in_ready, busy}, stored_count);
        end
        tick();
        n_checks++;
        if (wr_aq.size() - wb != 4) begin
            n_fail++;
            $display("FAIL s1_wr_count: got %0d want 4", wr_aq.size() - wb);
        end
        for (int i = 0; i < 4 && wb + i < wr_aq.size(); i++) begin
            n_checks++;
            if (wr_aq[wb+i] !== 19'h10 + 19'(i) || wr_dq[wb+i] !== {24'h0, rec_t(i), rec_l(i)}) begin
                n_fail++;
                $display("FAIL s1_wr%0d: addr %h data %h want addr %h", i, wr_aq[wb+i], wr_dq[wb+i], 19'h10 + 19'(i));
            end
        end
    endtask

    task automatic test_store_stop_replay();
        int rb, ob, db;
        logic [31:0] exp_rec;
        tick();
        start_store_at(19'h20, 19'h2F);
        store_recs(0, 3);
        pulse_stop();
        @(negedge clk);
        n_checks++;
        if (stored_count !== 20'd3 || {region_full, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL s2_stop: stored %0d full/busy %b want 3 00", stored_count, {region_full, busy});
        end
        tick();
        rb = rd_cnt; ob = out_tq.size(); db = done_cnt;
        out_ready = 1'b1;
        start_replay_at(19'h20, 16'd2);
        wait_done(db, 300, "s2");
        n_checks++;
        if (done_cnt - db != 1 || rd_cnt - rb != 6) begin
            n_fail++;
            $display("FAIL s2_done_reads: done %0d reads %0d want 1 6", done_cnt - db, rd_cnt - rb);
        end
        check_outputs(ob, 6, 0, "s2");
        exp_rec = 32'd0;
`ifdef DFLOW_REPLAY_STATS_EN
        exp_rec = 32'd6;
`endif
        n_checks++;
        if (stat_records !== exp_rec) begin
            n_fail++;
            $display("FAIL s2_stat_records: got %0d want %0d", stat_records, exp_rec);
        end
    endtask

    task automatic test_backpressure();
        int rb, ob, db;
        tick();
        rb = rd_cnt; ob = out_tq.size(); db = done_cnt;
        out_ready = 1'b0;
        start_replay_at(19'h20, 16'd10);
        repeat (40) tick();
        n_checks++;
        if (rd_cnt - rb != FD || max_occ != FD) begin
            n_fail++;
            $display("FAIL s3_credit: reads %0d occupancy %0d want %0d", rd_cnt - rb, max_occ, FD);
        end
        @(negedge clk);
        n_checks++;
        if (out_vld !== 1'b1 || tuple_out !== rec_t(0) || len_out !== rec_l(0)) begin
            n_fail++;
            $display("FAIL s3_head: vld %b %h/%h want 1 %h/%h", out_vld, tuple_out, len_out, rec_t(0), rec_l(0));
        end
        repeat (5) tick();
        @(negedge clk);
        n_checks++;
        if (tuple_out !== rec_t(0) || len_out !== rec_l(0)) begin
            n_fail++;
            $display("FAIL s3_hold: got %h/%h want %h/%h", tuple_out, len_out, rec_t(0), rec_l(0));
        end
        tick();
        out_ready = 1'b1;
        wait_done(db, 400, "s3");
        n_checks++;
        if (done_cnt - db != 1 || rd_cnt - rb != 30) begin
            n_fail++;
            $display("FAIL s3_done_reads: done %0d reads %0d want 1 30", done_cnt - db, rd_cnt - rb);
        end
        check_outputs(ob, 30, 0, "s3");
    endtask

    task automatic test_infinite_stop();
        int rb, ob, db, rs;
        tick();
        rb = rd_cnt; ob = out_tq.size(); db = done_cnt;
        out_ready = 1'b1;
        start_replay_at(19'h20, 16'd0);
        for (int c = 0; c < 1000 && out_tq.size() - ob < 100; c++) tick();
        n_checks++;
        if (out_tq.size() - ob < 100) begin
            n_fail++;
            $display("FAIL s4_run_timeout: outputs got %0d want >=100", out_tq.size() - ob);
        end
        stop = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_rd_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL s4_rd_at_stop: mem_rd_cmd got %b want 0", mem_rd_cmd);
        end
        tick();
        stop = 1'b0;
        rs = rd_cnt;
        wait_done(db, 200, "s4");
        n_checks++;
        if (rd_cnt != rs || done_cnt - db != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL s4_drain: reads after stop %0d done %0d busy %b want 0 1 0", rd_cnt - rs, done_cnt - db, busy);
        end
        n_checks++;
        if (max_occ > FD) begin
            n_fail++;
            $display("FAIL s4_occupancy: got %0d want <=%0d", max_occ, FD);
        end
        check_outputs(ob, rd_cnt - rb, 0, "s4");
    endtask

    task automatic test_cfg_err();
        int rb, wb, bb;
        tick();
        do_reset();
        rb = rd_cnt; wb = wr_aq.size(); bb = busy_cnt;
        start_replay_at(19'h0, 16'd1);
        @(negedge clk);
        n_checks++;
        if ({cfg_err, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL s5_empty_replay: cfg_err/busy got %b want 10", {cfg_err, busy});
        end
        tick();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL s5_err_cleared: cfg_err got %b want 0", cfg_err);
        end
        tick();
        start_store_at(19'h30, 19'h2F);
        @(negedge clk);
        n_checks++;
        if ({cfg_err, busy, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL s5_high_lt_low: cfg_err/busy/in_ready got %b want 100", {cfg_err, busy, in_ready});
        end
        tick();
        do_reset();
        init_calib_complete = 1'b0;
        start_store_at(19'h10, 19'h13);
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, cfg_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL s5_no_calib: busy/in_ready/cfg_err got %b want 000", {busy, in_ready, cfg_err});
        end
        tick();
        init_calib_complete = 1'b1;
        tick();
        n_checks++;
        if (rd_cnt != rb || wr_aq.size() != wb || busy_cnt != bb) begin
            n_fail++;
            $display("FAIL s5_quiet: reads %0d writes %0d busy cycles %0d want 0 0 0",
                     rd_cnt - rb, wr_aq.size() - wb, busy_cnt - bb);
        end
    endtask

    task automatic test_reset_midreplay();
        int ob;
        tick();
        start_store_at(19'h40, 19'h4F);
        store_recs(10, 3);
        pulse_stop();
        out_ready = 1'b0;
        start_replay_at(19'h40, 16'd0);
        repeat (6) tick();
        @(negedge clk);
        n_checks++;
        if ({busy, out_vld} !== 2'b11) begin
            n_fail++;
            $display("FAIL s6_pre: busy/out_vld got %b want 11", {busy, out_vld});
        end
        tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, out_vld, mem_rd_cmd, mem_wr_cmd, in_ready, replay_done, region_full, cfg_err} !== 8'h00 ||
            tuple_out !== '0 || len_out !== '0 || stored_count !== 20'd0) begin
            n_fail++;
            $display("FAIL s6_cleared: flags %b tuple %h len %h stored %0d want all 0",
                     {busy, out_vld, mem_rd_cmd, mem_wr_cmd, in_ready, replay_done, region_full, cfg_err},
                     tuple_out, len_out, stored_count);
        end
        tick();
        ob = out_tq.size();
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        n_checks++;
        if (out_tq.size() != ob || out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL s6_late_return: outputs %0d out_vld %b want 0 0", out_tq.size() - ob, out_vld);
        end
    endtask

    initial begin
        test_reset();
        test_store_full();
        test_store_stop_replay();
        test_backpressure();
        test_infinite_stop();
        test_cfg_err();
        test_reset_midreplay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
